// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-requester arbiter and access sequencer for a single-port data memory
module dmem_arbiter #(
  parameter int AW = 7,
  parameter int DW = 32,
  parameter int RD_LAT = 1,
  parameter int MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  input  logic          r0_lock,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  input  logic          r1_lock,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic          mem_oe,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  localparam int LW = $clog2(MAX_LOCK + 1);
  localparam logic [1:0] WL = 2'(RD_LAT - 1);
  localparam logic [LW-1:0] ML = LW'(MAX_LOCK);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic we_q, we_d, id_q, id_d, ptr_q, ptr_d, own_q, own_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [1:0] wcnt_q, wcnt_d;
  logic lk, glk, hold, gid, any;
  always_comb begin
    lk = ptr_q ? r1_lock : r0_lock;
    hold = own_q && lk && cnt_q < ML;
    gid = (r0_req && r1_req) ? (hold ? ptr_q : ~ptr_q) : r1_req;
    any = !rst && state_q == IDLE && (r0_req || r1_req);
    glk = gid ? r1_lock : r0_lock;
    r0_gnt = any && !gid;
    r1_gnt = any && gid;
    state_d = state_q;
    we_d = we_q;
    id_d = id_q;
    ptr_d = ptr_q;
    own_d = own_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    cnt_d = cnt_q;
    wcnt_d = wcnt_q;
    unique case (state_q)
      IDLE: if (any) begin
        state_d = ISSUE;
        id_d = gid;
        we_d = gid ? r1_we : r0_we;
        addr_d = gid ? r1_addr : r0_addr;
        wdata_d = gid ? r1_wdata : r0_wdata;
        ptr_d = gid;
        own_d = 1'b1;
        cnt_d = !glk ? '0 : (own_q && gid == ptr_q) ? (cnt_q == ML ? cnt_q : cnt_q + 1'b1) : LW'(1);
      end
      ISSUE: begin
        state_d = we_q ? IDLE : WAIT;
        wcnt_d = '0;
      end
      WAIT: begin
        state_d = wcnt_q == WL ? RESP : WAIT;
        wcnt_d = wcnt_q + 2'd1;
        rdata0_d = (wcnt_q == WL && !id_q) ? mem_rdata : rdata0_q;
        rdata1_d = (wcnt_q == WL && id_q) ? mem_rdata : rdata1_q;
      end
      RESP: state_d = IDLE;
    endcase
    mem_en = state_q == ISSUE;
    mem_we = mem_en && we_q;
    mem_oe = mem_en && !we_q;
    mem_addr = mem_en ? addr_q : '0;
    mem_wdata = mem_en ? wdata_q : '0;
    r0_rvalid = state_q == RESP && !id_q;
    r1_rvalid = state_q == RESP && id_q;
    r0_rdata = rdata0_q;
    r1_rdata = rdata1_q;
    busy = state_q != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      id_q <= 1'b0;
      ptr_q <= 1'b1;
      own_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      cnt_q <= '0;
      wcnt_q <= '0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      id_q <= id_d;
      ptr_q <= ptr_d;
      own_q <= own_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      cnt_q <= cnt_d;
      wcnt_q <= wcnt_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with RD_LAT=1 and RD_LAT=3 instances
module tb_dmem_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic r0_req = 0, r0_we = 0, r0_lock = 0, r1_req = 0, r1_we = 0, r1_lock = 0;
  logic [6:0] r0_addr = '0, r1_addr = '0;
  logic [31:0] r0_wdata = '0, r1_wdata = '0;
  logic r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, mem_en, mem_we, mem_oe, busy;
  logic [31:0] r0_rdata, r1_rdata, mem_wdata, mem_rdata;
  logic [6:0] mem_addr;
  logic b_r0_req = 0, b_r0_we = 0, b_r1_req = 0, b_r1_we = 0;
  logic [6:0] b_r0_addr = '0, b_r1_addr = '0;
  logic [31:0] b_r1_wdata = '0;
  logic b_r0_gnt, b_r0_rvalid, b_r1_gnt, b_r1_rvalid, b_mem_en, b_mem_we, b_mem_oe, b_busy;
  logic [31:0] b_r0_rdata, b_r1_rdata, b_mem_wdata, b_mem_rdata;
  logic [6:0] b_mem_addr;
  dmem_arbiter #(.RD_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_lock(r0_lock),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_lock(r1_lock),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_oe(mem_oe), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );
  dmem_arbiter #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .r0_req(b_r0_req), .r0_we(b_r0_we), .r0_addr(b_r0_addr), .r0_wdata(32'd0), .r0_lock(1'b0),
    .r0_gnt(b_r0_gnt), .r0_rvalid(b_r0_rvalid), .r0_rdata(b_r0_rdata),
    .r1_req(b_r1_req), .r1_we(b_r1_we), .r1_addr(b_r1_addr), .r1_wdata(b_r1_wdata), .r1_lock(1'b0),
    .r1_gnt(b_r1_gnt), .r1_rvalid(b_r1_rvalid), .r1_rdata(b_r1_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_oe(b_mem_oe), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );
  logic [31:0] m1 [128], m3 [128];
  logic [127:0] v1 = '0, v3 = '0;
  logic p1 = 1'b0, p3 = 1'b0;
  logic [1:0] c1 = '0, c3 = '0;
  logic [6:0] a1 = '0, a3 = '0;
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      m1[mem_addr] <= mem_wdata;
      v1[mem_addr] <= 1'b1;
    end
    if (mem_en && mem_oe) begin
      p1 <= 1'b1;
      c1 <= 2'd0;
      a1 <= mem_addr;
    end else if (p1) begin
      if (c1 == 2'd0) p1 <= 1'b0;
      else c1 <= c1 - 2'd1;
    end
  end
  always @(posedge clk) begin
    if (b_mem_en && b_mem_we) begin
      m3[b_mem_addr] <= b_mem_wdata;
      v3[b_mem_addr] <= 1'b1;
    end
    if (b_mem_en && b_mem_oe) begin
      p3 <= 1'b1;
      c3 <= 2'd2;
      a3 <= b_mem_addr;
    end else if (p3) begin
      if (c3 == 2'd0) p3 <= 1'b0;
      else c3 <= c3 - 2'd1;
    end
  end
  assign mem_rdata = (p1 && c1 == 2'd0) ? (v1[a1] ? m1[a1] : 32'hA5A50000 | {25'd0, a1}) : 32'hBAD0BAD0;
  assign b_mem_rdata = (p3 && c3 == 2'd0) ? (v3[a3] ? m3[a3] : 32'hA5A50000 | {25'd0, a3}) : 32'hBAD0BAD0;
  int errors = 0, checks = 0;
  int gq[$];
  logic [32:0] rq[$];
  logic [32:0] e;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (r0_gnt || r1_gnt) begin
      chk("gnt_onehot", 32'(r0_gnt && r1_gnt), 32'd0);
      if (gq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL gnt_unexpected: got grant to r%0d want none", r1_gnt);
      end else chk("gnt_id", 32'(r1_gnt), 32'(gq.pop_front()));
    end
    if (r0_rvalid || r1_rvalid) begin
      chk("rvalid_onehot", 32'(r0_rvalid && r1_rvalid), 32'd0);
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rvalid_unexpected: got rvalid on r%0d want none", r1_rvalid);
      end else begin
        e = rq.pop_front();
        chk("rvalid_id", 32'(r1_rvalid), 32'(e[32]));
        chk("rdata", r1_rvalid ? r1_rdata : r0_rdata, e[31:0]);
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end
  initial begin
    int n;
    step;
    step;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_en", 32'(mem_en), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_oe", 32'(mem_oe), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_rv", 32'(r0_rvalid | r1_rvalid), 0);
    chk("rst_rdata", r0_rdata | r1_rdata, 0);
    rst = 0;
    r0_req = 1; r0_we = 1; r0_addr = 7'h05; r0_wdata = 32'hDEADBEEF;
    gq.push_back(0);
    #1;
    chk("t1_gnt", 32'(r0_gnt), 1);
    step;
    r0_req = 0; r0_addr = 7'h7F; r0_wdata = 32'h0;
    #1;
    chk("t1_en", 32'(mem_en), 1);
    chk("t1_we", 32'(mem_we), 1);
    chk("t1_oe", 32'(mem_oe), 0);
    chk("t1_addr", 32'(mem_addr), 32'h05);
    chk("t1_wdata", mem_wdata, 32'hDEADBEEF);
    chk("t1_busy", 32'(busy), 1);
    step;
    chk("t1_idle", 32'(busy), 0);
    chk("t1_en_off", 32'(mem_en), 0);
    r1_req = 1; r1_we = 0; r1_addr = 7'h05;
    gq.push_back(1);
    rq.push_back({1'b1, 32'hDEADBEEF});
    #1;
    chk("t2_gnt", 32'(r1_gnt), 1);
    step;
    r1_req = 0;
    #1;
    chk("t2_oe", 32'(mem_oe), 1);
    chk("t2_we", 32'(mem_we), 0);
    chk("t2_addr", 32'(mem_addr), 32'h05);
    step;
    chk("t2_wait", 32'(r1_rvalid), 0);
    step;
    chk("t2_rvalid", 32'(r1_rvalid), 1);
    chk("t2_rdata", r1_rdata, 32'hDEADBEEF);
    chk("t2_r0v", 32'(r0_rvalid), 0);
    step;
    chk("t2_idle", 32'(busy), 0);
    chk("t2_hold", r1_rdata, 32'hDEADBEEF);
    r0_we = 1; r0_addr = 7'h10; r0_wdata = 32'h11111111;
    r1_we = 1; r1_addr = 7'h11; r1_wdata = 32'h22222222;
    r0_req = 1; r1_req = 1;
    foreach (gq[i]) chk("t3_gq_empty", 32'(gq.size()), 0);
    gq.push_back(0); gq.push_back(1); gq.push_back(0); gq.push_back(1);
    n = 0;
    for (int i = 0; i < 20 && n < 4; i++) begin
      #1;
      if (r0_gnt || r1_gnt) n++;
      step;
    end
    r0_req = 0; r1_req = 0;
    chk("t3_count", n, 4);
    step;
    r0_we = 0; r0_addr = 7'h10; r0_lock = 1;
    r1_we = 0; r1_addr = 7'h11;
    for (int i = 0; i < 10; i++) begin
      gq.push_back((i == 4 || i == 9) ? 1 : 0);
      rq.push_back((i == 4 || i == 9) ? {1'b1, 32'h22222222} : {1'b0, 32'h11111111});
    end
    r0_req = 1; r1_req = 1;
    n = 0;
    for (int i = 0; i < 80 && n < 10; i++) begin
      #1;
      if (r0_gnt || r1_gnt) n++;
      step;
    end
    r0_req = 0; r1_req = 0; r0_lock = 0;
    chk("t4_count", n, 10);
    repeat (4) step;
    r0_req = 1; r0_we = 0; r0_addr = 7'h05;
    gq.push_back(0);
    #1;
    chk("t5_gnt", 32'(r0_gnt), 1);
    step;
    r0_req = 0;
    #1;
    chk("t5_oe", 32'(mem_oe), 1);
    step;
    rst = 1;
    #1;
    chk("t5_busy_wait", 32'(busy), 1);
    step;
    rst = 0;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_en", 32'(mem_en), 0);
    chk("t5_oe_off", 32'(mem_oe), 0);
    chk("t5_rv", 32'(r0_rvalid), 0);
    chk("t5_rdata_clr", r0_rdata, 0);
    repeat (3) begin
      step;
      chk("t5_norv", 32'(r0_rvalid), 0);
    end
    r0_req = 1;
    gq.push_back(0);
    rq.push_back({1'b0, 32'hDEADBEEF});
    #1;
    chk("t5_regnt", 32'(r0_gnt), 1);
    step;
    r0_req = 0;
    step;
    step;
    chk("t5_rvalid", 32'(r0_rvalid), 1);
    chk("t5_rdata", r0_rdata, 32'hDEADBEEF);
    step;
    b_r0_req = 1; b_r0_we = 0; b_r0_addr = 7'h22;
    #1;
    chk("t6_gnt", 32'(b_r0_gnt), 1);
    step;
    b_r0_req = 0;
    #1;
    chk("t6_oe", 32'(b_mem_oe), 1);
    step;
    b_r1_req = 1; b_r1_we = 1; b_r1_addr = 7'h33; b_r1_wdata = 32'h00000001;
    #1;
    chk("t6_r1_wait", 32'(b_r1_gnt), 0);
    for (int k = 3; k <= 5; k++) begin
      step;
      chk("t6_r1_wait", 32'(b_r1_gnt), 0);
      chk("t6_rvalid", 32'(b_r0_rvalid), 32'(k == 5));
    end
    chk("t6_rdata", b_r0_rdata, 32'hA5A50022);
    step;
    chk("t6_r1_gnt", 32'(b_r1_gnt), 1);
    chk("t6_idle", 32'(b_busy), 0);
    step;
    b_r1_req = 0;
    #1;
    chk("t6_we", 32'(b_mem_we), 1);
    chk("t6_addr", 32'(b_mem_addr), 32'h33);
    step;
    chk("queues_drained", 32'(gq.size() + rq.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
